// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage RAM request responder:
// access size codes, FSM state encoding and byte lane helpers.
package mem_ctrl_pkg;

    localparam logic [1:0] MemSizeByte = 2'b00;
    localparam logic [1:0] MemSizeHalf = 2'b01;
    localparam logic [1:0] MemSizeWord = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RLAST,
        S_DONE
    } state_e;

    // Index of the last byte of an access; 2'b10 is also a word.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        logic [1:0] r;
        case (size)
            MemSizeByte: r = 2'd0;
            MemSizeHalf: r = 2'd1;
            default:     r = 2'd3;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w,
                                            input logic [1:0]  k);
        return w[8*k +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w,
                                             input logic [1:0]  k,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        r[8*k +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises 1/2/4-byte MEM-stage loads/stores onto a byte-wide
// synchronous RAM, little-endian, and returns read data with a done pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ram_r_req_i/ram_w_req_i  level requests, held until ram_done_o
//   ram_addr_i, ram_w_data_i byte address, store data
//   ram_state_i              size code (00 byte, 01 half, 1x word)
//   ram_done_o, ram_r_data_o one-cycle done, zero-extended load data
//   mem_din_i                RAM read byte, valid one cycle after address
//   mem_dout_o, mem_a_o      RAM write byte, RAM byte address
//   mem_wr_o                 RAM write strobe
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_r_req_i,
    input  logic                  ram_w_req_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [31:0]           ram_w_data_i,
    input  logic [1:0]            ram_state_i,
    output logic                  ram_done_o,
    output logic [31:0]           ram_r_data_o,
    input  logic [7:0]            mem_din_i,
    output logic [7:0]            mem_dout_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic                  mem_wr_o
);

    state_e                state_q, state_d;
    logic [1:0]            k_q, k_d;
    logic [1:0]            last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           asm_q, asm_d;
    logic                  done_q, done_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [7:0]            dout_q, dout_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic                  wr_q, wr_d;
    logic [1:0]            k_nx;
    logic [31:0]           asm_fin;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        dout_d  = 8'h00;
        a_d     = '0;
        wr_d    = 1'b0;
        k_nx    = k_q + 2'd1;
        asm_fin = put_byte(asm_q, k_q, mem_din_i);

        case (state_q)
            S_IDLE: begin
                // Write wins when both requests are high.
                if (ram_w_req_i) begin
                    state_d = S_WRITE;
                    k_d     = 2'd0;
                    last_d  = last_idx(ram_state_i);
                    addr_d  = ram_addr_i;
                    wdata_d = ram_w_data_i;
                    a_d     = ram_addr_i;
                    dout_d  = ram_w_data_i[7:0];
                    wr_d    = 1'b1;
                end else if (ram_r_req_i) begin
                    state_d = S_READ;
                    k_d     = 2'd0;
                    last_d  = last_idx(ram_state_i);
                    addr_d  = ram_addr_i;
                    asm_d   = 32'h0;
                    a_d     = ram_addr_i;
                end
            end
            S_WRITE: begin
                if (k_q == last_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    k_d    = k_nx;
                    a_d    = addr_q + ADDR_WIDTH'(k_nx);
                    dout_d = get_byte(wdata_q, k_nx);
                    wr_d   = 1'b1;
                end
            end
            S_READ: begin
                // Byte issued in the previous cycle arrives now.
                if (k_q != 2'd0)
                    asm_d = put_byte(asm_q, k_q - 2'd1, mem_din_i);
                if (k_q == last_q) begin
                    state_d = S_RLAST;
                end else begin
                    k_d = k_nx;
                    a_d = addr_q + ADDR_WIDTH'(k_nx);
                end
            end
            S_RLAST: begin
                asm_d   = asm_fin;
                rdata_d = asm_fin;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
            last_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            asm_q   <= 32'h0;
            done_q  <= 1'b0;
            rdata_q <= 32'h0;
            dout_q  <= 8'h00;
            a_q     <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
            a_q     <= a_d;
            wr_q    <= wr_d;
        end
    end

    assign ram_done_o   = done_q;
    assign ram_r_data_o = rdata_q;
    assign mem_dout_o   = dout_q;
    assign mem_a_o      = a_q;
    assign mem_wr_o     = wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: byte-wide RAM model, directed
// transactions, and a negedge monitor checking bus writes and done pulses.
module tb_mem_ctrl;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [7:0]  d;
    } wr_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] d;
    } dn_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_req, w_req;
    logic [31:0] addr, wdata;
    logic [1:0]  st;
    logic        done;
    logic [31:0] rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [31:0] last_rd = 32'h0;

    wr_exp_t wq[$];
    dn_exp_t dq[$];
    wr_exp_t we;
    dn_exp_t de;

    logic [7:0] ram [logic [31:0]];

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ram_r_req_i  (r_req),
        .ram_w_req_i  (w_req),
        .ram_addr_i   (addr),
        .ram_w_data_i (wdata),
        .ram_state_i  (st),
        .ram_done_o   (done),
        .ram_r_data_o (rdata),
        .mem_din_i    (mem_din),
        .mem_dout_o   (mem_dout),
        .mem_a_o      (mem_a),
        .mem_wr_o     (mem_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_wr) begin
                n_cmp++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected cyc=%0d a=%h d=%h, required no write",
                             cyc, mem_a, mem_dout);
                end else begin
                    we = wq.pop_front();
                    if (we.cyc != cyc || we.a != mem_a || we.d != mem_dout) begin
                        n_fail++;
                        $display("FAIL wr_byte got cyc=%0d a=%h d=%h, required cyc=%0d a=%h d=%h",
                                 cyc, mem_a, mem_dout, we.cyc, we.a, we.d);
                    end
                end
            end
            if (done) begin
                n_cmp++;
                if (dq.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected cyc=%0d, required no done", cyc);
                end else begin
                    de = dq.pop_front();
                    if (de.cyc != cyc || de.d != rdata) begin
                        n_fail++;
                        $display("FAIL done got cyc=%0d rdata=%h, required cyc=%0d rdata=%h",
                                 cyc, rdata, de.cyc, de.d);
                    end
                end
            end
        end
    end

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic txn(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s,
                       input logic [31:0] exp_rd, input bit drop);
        int c0;
        int n;
        bit got;
        c0 = cyc;
        n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        w_req = w;
        r_req = r;
        addr  = a;
        wdata = d;
        st    = s;
        if (w) begin
            for (int k = 0; k < n; k++)
                wq.push_back('{c0 + 1 + k, a + k, d[8*k +: 8]});
            dq.push_back('{c0 + n + 1, last_rd});
        end else begin
            dq.push_back('{c0 + n + 2, exp_rd});
            last_rd = exp_rd;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (drop && cyc == c0 + 1) begin
                w_req = 1'b0;
                r_req = 1'b0;
            end
            if (!w && cyc >= c0 + 1 && cyc <= c0 + n) begin
                n_cmp++;
                if (mem_a != a + 32'(cyc - c0 - 1) || mem_wr) begin
                    n_fail++;
                    $display("FAIL rd_addr cyc=%0d got a=%h wr=%b, required a=%h wr=0",
                             cyc, mem_a, mem_wr, a + 32'(cyc - c0 - 1));
                end
            end
            if (done) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout addr=%h got no done, required done", a);
        end
        @(posedge clk);
        #1;
        w_req = 1'b0;
        r_req = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        r_req = 1'b0;
        w_req = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        st    = 2'b00;
        ram[32'h200] = 8'h80;
        ram[32'h301] = 8'h34;
        ram[32'h302] = 8'h12;
        ram[32'h11]  = 8'h66;
        ram[32'h12]  = 8'h77;
        ram[32'h13]  = 8'h88;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done || rdata != 0 || mem_dout != 0 || mem_a != 0 || mem_wr) begin
            n_fail++;
            $display("FAIL reset_state got done=%b rd=%h dout=%h a=%h wr=%b, required all 0",
                     done, rdata, mem_dout, mem_a, mem_wr);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        txn(1'b1, 1'b0, 32'h100, 32'hA1B2C3D4, 2'b11, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 32'h200, 32'h0, 2'b00, 32'h00000080, 1'b0);
        txn(1'b0, 1'b1, 32'h301, 32'h0, 2'b01, 32'h00001234, 1'b0);
        txn(1'b1, 1'b0, 32'h10, 32'hFFFFFF55, 2'b00, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 32'h10, 32'h0, 2'b11, 32'h88776655, 1'b0);
        txn(1'b1, 1'b0, 32'hFFFFFFFE, 32'hCAFEF00D, 2'b10, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 32'hFFFFFFFE, 32'h0, 2'b11, 32'hCAFEF00D, 1'b0);
        txn(1'b1, 1'b1, 32'h500, 32'h1234BEEF, 2'b01, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 32'h500, 32'h0, 2'b01, 32'h0000BEEF, 1'b1);

        // Reset during the second byte of a word store.
        w_req = 1'b1;
        addr  = 32'h400;
        wdata = 32'h11223344;
        st    = 2'b11;
        wq.push_back('{cyc + 1, 32'h400, 8'h44});
        wq.push_back('{cyc + 2, 32'h401, 8'h33});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        w_req = 1'b0;
        last_rd = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (mem_wr || done || rdata != 0) begin
            n_fail++;
            $display("FAIL rst_abort got wr=%b done=%b rd=%h, required 0 0 0",
                     mem_wr, done, rdata);
        end
        repeat (3) @(posedge clk);
        #1;
        txn(1'b0, 1'b1, 32'h401, 32'h0, 2'b00, 32'h00000033, 1'b0);
        txn(1'b1, 1'b0, 32'h400, 32'h11223344, 2'b11, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 32'h403, 32'h0, 2'b00, 32'h00000011, 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (wq.size() != 0 || dq.size() != 0) begin
            n_fail++;
            $display("FAIL drain got wq=%0d dq=%0d pending, required 0 0",
                     wq.size(), dq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
